reg_dump_reader: RTL

//  Debug reader for the 16-bit register file.
//  - On a start pulse, walks R0..R(NUM_REGS-1) through one register-file read port.
//  - Streams each value out on a valid/ready interface, with its index and a last flag.
//  - Asserts halt_req while active so the core can freeze writes and the dump stays coherent.
//  - Sits beside the core, between the register file read port and the debug/trace link.

---
 rtl/reg_dump_reader.sv | 90 +++++++++
 1 files changed

// File: rtl/reg_dump_reader.sv
// Debug reader that walks the register file through one read port and streams
// every register out on a valid/ready link, freezing core writes while it runs.
module reg_dump_reader #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int NUM_REGS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              halt_req,
    output logic              done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] SEND = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] idx;

    // Termination relies only on the out_last compare, so idx never needs to wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            idx       <= '0;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else if (abort && state != IDLE) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        idx   <= '0;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    out_data  <= rd_data;
                    out_index <= idx;
                    out_last  <= (idx == LAST_IDX);
                    out_valid <= 1'b1;
                    state     <= SEND;
                end
                SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            state <= DONE;
                        end else begin
                            idx   <= idx + ADDR_W'(1);
                            state <= LOAD;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The read port only carries idx while a value is being captured.
    always_comb begin
        rd_addr  = (state == LOAD) ? idx : '0;
        busy     = (state != IDLE);
        halt_req = (state != IDLE);
        done     = (state == DONE);
    end

endmodule
